// File: rtl/shift_seq_detector_if.sv
// Signal bundle between the step-driven shift/detect core and its environment.
// The master drives key, serial and control inputs; the slave returns the register state and strobe.
interface shift_seq_detector_if #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned CNT_W = 8
);
    logic             key;
    logic             x;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] pdata;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] mask;
    logic             overlap;
    logic [WIDTH-1:0] q;
    logic             z;
    logic             last;
    logic [CNT_W-1:0] match_cnt;
    logic             step;

    modport master (
        output key, x, dir, load, pdata, pattern, mask, overlap,
        input  q, z, last, match_cnt, step
    );

    modport slave (
        input  key, x, dir, load, pdata, pattern, mask, overlap,
        output q, z, last, match_cnt, step
    );
endinterface

// File: rtl/shift_seq_detector.sv
// Debounced-key-stepped shift register with masked pattern detection,
// optional non-overlapping blanking and a saturating match counter.
module shift_seq_detector #(
    parameter int unsigned WIDTH      = 6,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 8
) (
    input logic                 clk,
    input logic                 reset,
    shift_seq_detector_if.slave bus
);
    localparam int unsigned DebW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned BlankW = $clog2(WIDTH);
    localparam logic [DebW-1:0]   DebLast   = DebW'(DEB_CYCLES - 1);
    localparam logic [BlankW-1:0] BlankInit = BlankW'(WIDTH - 1);

    logic [1:0]        sync_q;
    logic              stable_q, stable_d;
    logic              stable_dly_q;
    logic [DebW-1:0]   deb_cnt_q, deb_cnt_d;
    logic              step_q;

    logic [WIDTH-1:0]  q_q, q_d;
    logic              z_q, z_d;
    logic              last_q, last_d;
    logic [BlankW-1:0] blank_q, blank_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  q_shift;
    logic              hit;

    // Stable level flips only after DEB_CYCLES consecutive disagreeing clocks.
    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = '0;
        if (sync_q[1] != stable_q) begin
            if (deb_cnt_q == DebLast) begin
                stable_d = ~stable_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q       <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            deb_cnt_q    <= '0;
            step_q       <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], bus.key};
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            deb_cnt_q    <= deb_cnt_d;
            step_q       <= stable_q & ~stable_dly_q;
        end
    end

    always_comb begin
        q_shift = bus.dir ? {bus.x, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], bus.x};
        hit     = ((q_shift ^ bus.pattern) & bus.mask) == '0;
    end

    always_comb begin
        q_d     = q_q;
        z_d     = z_q;
        last_d  = last_q;
        blank_d = blank_q;
        cnt_d   = cnt_q;
        if (step_q) begin
            if (bus.load) begin
                q_d     = bus.pdata;
                z_d     = 1'b0;
                blank_d = '0;
            end else begin
                q_d    = q_shift;
                last_d = bus.x;
                if (bus.overlap) begin
                    z_d = hit;
                end else if (blank_q != '0) begin
                    // Suppress hits that overlap the previously reported match.
                    blank_d = blank_q - 1'b1;
                    z_d     = 1'b0;
                end else if (hit) begin
                    z_d     = 1'b1;
                    blank_d = BlankInit;
                end else begin
                    z_d = 1'b0;
                end
                if (z_d && (cnt_q != '1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q     <= '0;
            z_q     <= 1'b0;
            last_q  <= 1'b0;
            blank_q <= '0;
            cnt_q   <= '0;
        end else begin
            q_q     <= q_d;
            z_q     <= z_d;
            last_q  <= last_d;
            blank_q <= blank_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.q         = q_q;
    assign bus.z         = z_q;
    assign bus.last      = last_q;
    assign bus.match_cnt = cnt_q;
    assign bus.step      = step_q;
endmodule

// File: tb/tb_shift_seq_detector.sv
// Directed bench: debounce latency, overlap/non-overlap detection, load/mask/dir,
// counter saturation (second instance with CNT_W=2) and asynchronous reset.
module tb_shift_seq_detector;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    shift_seq_detector_if #(.WIDTH(6), .CNT_W(8)) dut_if ();
    shift_seq_detector_if #(.WIDTH(6), .CNT_W(2)) sat_if ();

    shift_seq_detector #(.WIDTH(6), .DEB_CYCLES(4), .CNT_W(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if)
    );

    shift_seq_detector #(.WIDTH(6), .DEB_CYCLES(4), .CNT_W(2)) u_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sat_if)
    );

    assign sat_if.key     = dut_if.key;
    assign sat_if.x       = dut_if.x;
    assign sat_if.dir     = dut_if.dir;
    assign sat_if.load    = dut_if.load;
    assign sat_if.pdata   = dut_if.pdata;
    assign sat_if.pattern = dut_if.pattern;
    assign sat_if.mask    = dut_if.mask;
    assign sat_if.overlap = dut_if.overlap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b0;
        dut_if.key  = 1'b0;
        dut_if.load = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // One accepted key press; returns with the step's update visible on the outputs.
    task automatic press();
        int lat;
        lat = 0;
        @(negedge clk);
        dut_if.key = 1'b1;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (dut_if.step) lat = i;
        end
        checks++;
        if (lat == 0) begin
            errors++;
            $display("FAIL press_timeout: step stayed 0, required 1 within 20 clocks");
        end else begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        dut_if.key = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (dut_if.q !== 6'h00) begin
            errors++; $display("FAIL reset_q: got %h required 00", dut_if.q);
        end
        checks++;
        if (dut_if.z !== 1'b0) begin
            errors++; $display("FAIL reset_z: got %b required 0", dut_if.z);
        end
        checks++;
        if (dut_if.last !== 1'b0) begin
            errors++; $display("FAIL reset_last: got %b required 0", dut_if.last);
        end
        checks++;
        if (dut_if.match_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d required 0", dut_if.match_cnt);
        end
        checks++;
        if (dut_if.step !== 1'b0) begin
            errors++; $display("FAIL reset_step: got %b required 0", dut_if.step);
        end
    endtask

    task automatic test_debounce();
        int bounce_steps, first, total, rel_steps;
        do_reset();
        dut_if.mask    = 6'h3F;
        dut_if.pattern = 6'h3F;
        bounce_steps = 0; first = 0; total = 0; rel_steps = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dut_if.key = ~dut_if.key;
            repeat (2) begin
                @(posedge clk); #1;
                if (dut_if.step) bounce_steps++;
            end
        end
        @(negedge clk);
        dut_if.key = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (dut_if.step) begin
                total++;
                if (first == 0) first = i;
            end
        end
        checks++;
        if (bounce_steps !== 0) begin
            errors++; $display("FAIL deb_bounce: got %0d steps required 0", bounce_steps);
        end
        checks++;
        if (first !== 7) begin
            errors++; $display("FAIL deb_latency: got %0d clocks required 7", first);
        end
        checks++;
        if (total !== 1) begin
            errors++; $display("FAIL deb_single: got %0d steps required 1", total);
        end
        @(negedge clk);
        dut_if.key = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (dut_if.step) rel_steps++;
        end
        checks++;
        if (rel_steps !== 0) begin
            errors++; $display("FAIL deb_release: got %0d steps required 0", rel_steps);
        end
    endtask

    task automatic test_overlap();
        logic [7:0] xs;
        logic [7:0] zexp;
        xs   = 8'b1010_1010;
        zexp = 8'b1010_0000;
        do_reset();
        dut_if.dir = 1'b0; dut_if.mask = 6'h3F; dut_if.pattern = 6'b010101;
        dut_if.overlap = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dut_if.x = xs[i];
            press();
            checks++;
            if (dut_if.z !== zexp[i]) begin
                errors++;
                $display("FAIL ovl_z_step%0d: got %b required %b", i + 1, dut_if.z, zexp[i]);
            end
        end
        checks++;
        if (dut_if.match_cnt !== 8'd2) begin
            errors++; $display("FAIL ovl_cnt: got %0d required 2", dut_if.match_cnt);
        end
        checks++;
        if (dut_if.q !== 6'b010101) begin
            errors++; $display("FAIL ovl_q: got %h required 15", dut_if.q);
        end
    endtask

    task automatic test_non_overlap();
        logic [7:0] xs;
        logic [7:0] zexp;
        xs   = 8'b1010_1010;
        zexp = 8'b0010_0000;
        do_reset();
        dut_if.dir = 1'b0; dut_if.mask = 6'h3F; dut_if.pattern = 6'b010101;
        dut_if.overlap = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dut_if.x = xs[i];
            press();
            checks++;
            if (dut_if.z !== zexp[i]) begin
                errors++;
                $display("FAIL novl_z_step%0d: got %b required %b", i + 1, dut_if.z, zexp[i]);
            end
        end
        checks++;
        if (dut_if.match_cnt !== 8'd1) begin
            errors++; $display("FAIL novl_cnt: got %0d required 1", dut_if.match_cnt);
        end
        checks++;
        if (dut_if.last !== 1'b1) begin
            errors++; $display("FAIL novl_last: got %b required 1", dut_if.last);
        end
    endtask

    task automatic test_load_mask_dir();
        do_reset();
        dut_if.dir = 1'b0; dut_if.x = 1'b0; dut_if.mask = 6'h00; dut_if.overlap = 1'b1;
        press();
        checks++;
        if (dut_if.z !== 1'b1) begin
            errors++; $display("FAIL lmd_pre_z: got %b required 1", dut_if.z);
        end
        dut_if.load = 1'b1; dut_if.pdata = 6'h2A;
        press();
        repeat (5) @(negedge clk);
        checks++;
        if (dut_if.q !== 6'h2A) begin
            errors++; $display("FAIL lmd_load_q: got %h required 2a", dut_if.q);
        end
        checks++;
        if (dut_if.z !== 1'b0) begin
            errors++; $display("FAIL lmd_load_z: got %b required 0", dut_if.z);
        end
        checks++;
        if (dut_if.match_cnt !== 8'd1 || dut_if.last !== 1'b0) begin
            errors++;
            $display("FAIL lmd_load_hold: got cnt=%0d last=%b required cnt=1 last=0",
                     dut_if.match_cnt, dut_if.last);
        end
        dut_if.load = 1'b0; dut_if.dir = 1'b1; dut_if.x = 1'b1;
        dut_if.mask = 6'b011111; dut_if.pattern = 6'b110101;
        press();
        checks++;
        if (dut_if.q !== 6'h35) begin
            errors++; $display("FAIL lmd_shift_q: got %h required 35", dut_if.q);
        end
        checks++;
        if (dut_if.z !== 1'b1 || dut_if.last !== 1'b1) begin
            errors++;
            $display("FAIL lmd_shift_zl: got z=%b last=%b required z=1 last=1",
                     dut_if.z, dut_if.last);
        end
    endtask

    task automatic test_saturation_reset();
        int first, total;
        do_reset();
        dut_if.mask = 6'h00; dut_if.overlap = 1'b1; dut_if.dir = 1'b0; dut_if.x = 1'b1;
        repeat (5) press();
        checks++;
        if (sat_if.match_cnt !== 2'd3) begin
            errors++; $display("FAIL sat_cnt: got %0d required 3", sat_if.match_cnt);
        end
        checks++;
        if (dut_if.match_cnt !== 8'd5) begin
            errors++; $display("FAIL nosat_cnt: got %0d required 5", dut_if.match_cnt);
        end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (dut_if.q !== 6'h00 || dut_if.z !== 1'b0 || dut_if.last !== 1'b0 ||
            dut_if.match_cnt !== 8'd0 || sat_if.match_cnt !== 2'd0 || sat_if.q !== 6'h00) begin
            errors++;
            $display("FAIL async_reset: got q=%h z=%b last=%b cnt=%0d satcnt=%0d required all 0",
                     dut_if.q, dut_if.z, dut_if.last, dut_if.match_cnt, sat_if.match_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        dut_if.key = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        first = 0; total = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (dut_if.step) begin
                total++;
                if (first == 0) first = i;
            end
        end
        checks++;
        if (first !== 7 || total !== 1) begin
            errors++;
            $display("FAIL reset_mid_deb: got latency=%0d steps=%0d required latency=7 steps=1",
                     first, total);
        end
        dut_if.key = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset          = 1'b0;
        dut_if.key     = 1'b0;
        dut_if.x       = 1'b0;
        dut_if.dir     = 1'b0;
        dut_if.load    = 1'b0;
        dut_if.pdata   = 6'h00;
        dut_if.pattern = 6'h00;
        dut_if.mask    = 6'h3F;
        dut_if.overlap = 1'b1;
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        test_debounce();
        test_overlap();
        test_non_overlap();
        test_load_mask_dir();
        test_saturation_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_seq_detector.md
SHIFT_SEQ_DETECTOR -- requirements
Module: shift_seq_detector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, meaning shift register length (2..32).
REQ-002 The block SHALL have parameter DEB_CYCLES, default 4, meaning consecutive stable clocks required to accept a key level change (>=1).
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-004 The block SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-006 The block SHALL have port key, input, 1, meaning raw asynchronous step button.
REQ-007 The block SHALL have port x, input, 1, meaning serial data bit.
REQ-008 The block SHALL have port dir, input, 1, meaning 0 shifts toward MSB (x enters bit 0) and 1 shifts toward LSB (x enters bit WIDTH-1).
REQ-009 The block SHALL have port load, input, 1, meaning parallel-load request applied on the next step.
REQ-010 The block SHALL have port pdata, input, WIDTH, meaning parallel-load value.
REQ-011 The block SHALL have port pattern, input, WIDTH, meaning target sequence.
REQ-012 The block SHALL have port mask, input, WIDTH, meaning compare enable per bit (1 = compared).
REQ-013 The block SHALL have port overlap, input, 1, meaning 1 for overlapping detection and 0 for non-overlapping detection.
REQ-014 The block SHALL have port q, output, WIDTH, meaning register contents.
REQ-015 The block SHALL have port z, output, 1, meaning match flag.
REQ-016 The block SHALL have port last, output, 1, meaning x captured at the most recent shift.
REQ-017 The block SHALL have port match_cnt, output, CNT_W, meaning number of matches.
REQ-018 The block SHALL have port step, output, 1, meaning one-clock debounced key-press strobe.

Function
REQ-019 Key SHALL pass a 2-flop synchroniser, then a debouncer whose stable level toggles only after the synchronised level differs from it for DEB_CYCLES consecutive clocks; any bounce clears the count.
REQ-020 step SHALL be a registered rising-edge detect of the stable level: high exactly one clock per accepted press, first high DEB_CYCLES+3 rising edges after key rises and holds; release produces no step.
REQ-021 All register/detector updates SHALL occur only at clock edges where step=1; otherwise q, z, last, and match_cnt hold.
REQ-022 On step with load=1 (priority over shift), q SHALL take pdata, z SHALL go 0, the blanking counter SHALL clear, and last and match_cnt SHALL hold.
REQ-023 On step with load=0, q SHALL shift per dir with x inserted, and last SHALL take x.
REQ-024 A hit SHALL be defined as ((q_next XOR pattern) AND mask) == 0, evaluated on the post-shift value q_next.
REQ-025 With overlap=1, on each shift z SHALL take the hit value.
REQ-026 With overlap=0, on a hit z SHALL go 1 and a blanking counter SHALL be set to WIDTH-1.
REQ-027 With overlap=0, while the blanking counter is nonzero each shift SHALL decrement it and force z to 0; hits during blanking SHALL be ignored.
REQ-028 match_cnt SHALL increment on every shift that sets z=1 and saturate at all-ones without wrapping.
REQ-029 mask=0 SHALL make every shift a hit (subject to blanking).
REQ-030 Changing overlap, pattern, or mask between steps SHALL take effect at the next step; the blanking counter SHALL be unaffected by overlap changes.

Reset
REQ-031 While reset=0, q SHALL be 0, z SHALL be 0, last SHALL be 0, match_cnt SHALL be 0, step SHALL be 0, the blanking counter SHALL be 0, the synchroniser and stable level SHALL be 0, and the debounce count SHALL be 0, all immediately and independent of clk.
REQ-032 Reset asserted mid-debounce or mid-blanking SHALL discard that progress; after release, a key already held high SHALL produce one step after the full DEB_CYCLES+3 latency.

Verification
REQ-033 Debounce check: DEB_CYCLES=4, key toggles every 2 clocks for 20 clocks then held high -> exactly one step, 7 clocks after the final rise; key release -> no step.
REQ-034 Overlap detection check: WIDTH=6, dir=0, mask=6'h3F, pattern=6'b010101, overlap=1, x stream 0,1,0,1,0,1,0,1 one bit per step -> z=1 after steps 6 and 8, match_cnt=2.
REQ-035 Non-overlap detection check: same stream as REQ-034 with overlap=0 -> z=1 after step 6 only, match_cnt=1.
REQ-036 Mask, dir, and load check: mask=6'b011111, pattern=6'b110101, dir=1, load pdata=6'h2A then shift x=1 -> q=6'h35, z=1, last=1.
REQ-037 Saturation and reset check: CNT_W=2, mask=0, overlap=1, 5 steps -> match_cnt=3; reset pulse low mid-run -> all outputs 0 asynchronously.
